// File: rtl/spram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spram_fifo_ctrl
// Description : FIFO controller in front of a single-port RAM with a
//               one-cycle read latency. Bytes arrive over a valid/ready push
//               interface and are written to the RAM. They are prefetched back
//               in order into a registered output stage with its own
//               valid/ready handshake. The single RAM port is shared between
//               writes and read prefetches. When both want the port in the
//               same cycle, a priority bit decides, so under contention the
//               two strictly alternate.
//
// Ports       : clk, rst            clock, synchronous active-high reset
//               wr_valid/wr_ready   push handshake, wr_data = pushed word
//               rd_valid/rd_ready   pop handshake, rd_data = registered word
//               ram_data/ram_addr/  single-port RAM request (ram_data is
//               ram_we              wr_data passed straight through)
//               ram_q               RAM read data, one cycle after the address
//               count               words held: RAM + in-flight read + output
//
// Revision    : 1.0  initial release
// ============================================================================
module spram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH-1:0] c_last_ptr = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_depth    = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_mem_count;
    logic                  r_pend;      // RAM read issued last edge, data on ram_q now
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_prio;      // 1: read wins the next conflict

    logic w_mem_empty;
    logic w_mem_full;
    logic w_rd_req;
    logic w_wr_req;
    logic w_rd_gnt;
    logic w_wr_gnt;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == c_last_ptr) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign w_mem_empty = (r_mem_count == '0);
    assign w_mem_full  = (r_mem_count == c_depth);

    // A prefetch is only issued when the output register is guaranteed to be
    // free on the capture edge, so pend and rd_valid are never both set.
    assign w_rd_req = !w_mem_empty && !r_pend && (!r_rd_valid || rd_ready);
    assign w_wr_req = wr_valid && !w_mem_full;

    assign w_rd_gnt = w_rd_req && (!w_wr_req || r_prio);
    assign w_wr_gnt = w_wr_req && !w_rd_gnt;

    // "Read wins" is judged as if a write were requesting, which keeps
    // wr_ready free of any combinational path from wr_valid. When it is high
    // and wr_valid is high, the write is the grant.
    assign wr_ready = !rst && !w_mem_full && !(w_rd_req && r_prio);

    assign ram_data = wr_data;
    assign ram_we   = w_wr_gnt && !rst;
    assign ram_addr = w_wr_gnt ? r_wr_ptr : r_rd_ptr;

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign count    = r_mem_count
                    + {{ADDR_WIDTH{1'b0}}, r_pend}
                    + {{ADDR_WIDTH{1'b0}}, r_rd_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_pend      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_prio      <= 1'b1;
        end else begin
            if (w_wr_gnt) begin
                r_wr_ptr    <= ptr_inc(r_wr_ptr);
                r_mem_count <= r_mem_count + (ADDR_WIDTH + 1)'(1);
            end else if (w_rd_gnt) begin
                r_rd_ptr    <= ptr_inc(r_rd_ptr);
                r_mem_count <= r_mem_count - (ADDR_WIDTH + 1)'(1);
            end

            if (w_wr_gnt || w_rd_gnt) begin
                r_prio <= w_wr_gnt;
            end

            // A read grant and a capture cannot coincide (the read request
            // requires !pend), so these two assignments never collide.
            if (r_pend) begin
                r_rd_data  <= ram_q;
                r_rd_valid <= 1'b1;
                r_pend     <= 1'b0;
            end else begin
                if (r_rd_valid && rd_ready) begin
                    r_rd_valid <= 1'b0;
                end
                if (w_rd_gnt) begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spram_fifo_ctrl
// Description : Self-checking bench for spram_fifo_ctrl with a behavioural
//               single-port RAM (one-cycle read latency). A table of
//               per-cycle vectors covers reset, the first pushes/pops and
//               single-byte latency. Hand-written sequences cover full,
//               streaming contention with pointer wrap, and reset during an
//               in-flight read.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;
    logic [6:0] count;

    spram_fifo_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (6),
        .DEPTH      (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .count    (count)
    );

    // Single-port RAM model, registered read.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;      // writes since last reset -> expected write address
    int addr_bad = 0;
    int proto_bad = 0;
    int alt_bad = 0;
    logic [7:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       e_wr_ready;
        logic       e_we;
        logic [5:0] e_addr;
        logic       e_rv;
        logic [7:0] e_rd;
        logic [6:0] e_cnt;
    } vec_t;

    vec_t vecs [20];

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        wr_cnt = 0;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push n_push bytes (first, first+1, ...) and collect n_pop pops against
    // the scoreboard, one clock per iteration, with a cycle budget.
    task automatic drive(input int n_push, input int first, input bit rr,
                         input int n_pop, input int max_cyc, input bit chk_alt);
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        logic prev_we = 1'b0;
        logic acc, pop;
        logic [7:0] exp;
        while (pushed < n_push || popped < n_pop) begin
            if (cyc >= max_cyc) begin
                checks++; errors++;
                $display("FAIL drive timeout: pushed %0d of %0d, popped %0d of %0d",
                         pushed, n_push, popped, n_pop);
                break;
            end
            wr_valid = (pushed < n_push);
            wr_data  = 8'(first + pushed);
            rd_ready = rr;
            @(negedge clk);
            acc = wr_valid && wr_ready;
            pop = rd_valid && rd_ready;
            if (ram_we !== acc) proto_bad++;
            if (ram_we === 1'b1) begin
                if (ram_addr !== 6'(wr_cnt % 64) || ram_data !== wr_data) addr_bad++;
                wr_cnt++;
            end
            if (chk_alt && wr_valid) begin
                if (cyc == 0) begin
                    if (ram_we !== 1'b1) alt_bad++;
                end else if (ram_we === prev_we) begin
                    alt_bad++;
                end
            end
            prev_we = ram_we;
            if (pop) begin
                popped++;
                if (sb.size() == 0) begin
                    check("pop with nothing outstanding", 1, 0);
                end else begin
                    exp = sb.pop_front();
                    check("pop data order", {24'h0, rd_data}, {24'h0, exp});
                end
            end
            if (acc) begin
                sb.push_back(wr_data);
                pushed++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              rst   wv    wd     rr  | wr_rdy we    addr   rv    rd     cnt
        vecs[0]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 7'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 8'h00, 7'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 7'd1};
        vecs[3]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 8'h00, 7'd1};
        vecs[4]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 6'd2, 1'b1, 8'h01, 7'd2};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 6'd1, 1'b1, 8'h01, 7'd3};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 6'd1, 1'b1, 8'h01, 7'd3};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6'd1, 1'b1, 8'h01, 7'd3};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd2, 1'b0, 8'h01, 7'd2};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd2, 1'b1, 8'h02, 7'd2};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd3, 1'b0, 8'h02, 7'd1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd3, 1'b1, 8'h03, 7'd1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd3, 1'b0, 8'h03, 7'd0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd3, 1'b0, 8'h03, 7'd0};
        vecs[14] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 8'h00, 7'd0};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 7'd1};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0, 8'h00, 7'd1};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 6'd1, 1'b1, 8'h5A, 7'd1};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd1, 1'b1, 8'h5A, 7'd1};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0, 8'h5A, 7'd0};

        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---- vector table: reset, push 01/02/03, drain, single-byte latency
        for (int i = 0; i < 20; i++) begin
            rst      = vecs[i].rst;
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            rd_ready = vecs[i].rr;
            @(negedge clk);
            check($sformatf("v%0d wr_ready", i), {31'h0, wr_ready}, {31'h0, vecs[i].e_wr_ready});
            check($sformatf("v%0d ram_we", i),   {31'h0, ram_we},   {31'h0, vecs[i].e_we});
            check($sformatf("v%0d ram_addr", i), {26'h0, ram_addr}, {26'h0, vecs[i].e_addr});
            check($sformatf("v%0d rd_valid", i), {31'h0, rd_valid}, {31'h0, vecs[i].e_rv});
            check($sformatf("v%0d rd_data", i),  {24'h0, rd_data},  {24'h0, vecs[i].e_rd});
            check($sformatf("v%0d count", i),    {25'h0, count},    {25'h0, vecs[i].e_cnt});
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0; rd_ready = 1'b0;

        // ---- full: 65 bytes with no pops, 66th held back, then drain
        do_reset();
        drive(65, 8'h00, 1'b0, 0, 300, 1'b0);
        idle(4);
        @(negedge clk);
        check("full count", {25'h0, count}, 32'd65);
        check("full rd_valid", {31'h0, rd_valid}, 32'd1);
        check("full rd_data head", {24'h0, rd_data}, 32'h00);
        wr_valid = 1'b1; wr_data = 8'h41;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("full hold %0d wr_ready", k), {31'h0, wr_ready}, 32'd0);
            check($sformatf("full hold %0d ram_we", k),   {31'h0, ram_we},   32'd0);
            @(posedge clk);
            #1;
        end
        drive(1, 8'h41, 1'b1, 66, 600, 1'b0);
        idle(2);
        @(negedge clk);
        check("full drained count", {25'h0, count}, 32'd0);
        check("full drained rd_valid", {31'h0, rd_valid}, 32'd0);

        // ---- streaming under contention: 200 bytes, pointer wrap x3
        do_reset();
        drive(200, 8'h00, 1'b1, 200, 1500, 1'b1);
        check("stream grant alternation", alt_bad, 0);
        check("stream all consumed", sb.size(), 0);
        idle(2);
        @(negedge clk);
        check("stream end count", {25'h0, count}, 32'd0);

        // ---- reset while a read is in flight
        do_reset();
        drive(11, 8'h30, 1'b0, 0, 100, 1'b0);
        idle(3);
        @(negedge clk);
        check("pre-reset count", {25'h0, count}, 32'd11);
        check("pre-reset rd_data", {24'h0, rd_data}, 32'h30);
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
        @(negedge clk);
        check("pend count", {25'h0, count}, 32'd10);
        check("pend rd_valid", {31'h0, rd_valid}, 32'd0);
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
        #1;
        check("in-reset ram_we", {31'h0, ram_we}, 32'd0);
        check("in-reset wr_ready", {31'h0, wr_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; wr_valid = 1'b0;
        sb.delete(); wr_cnt = 0;
        @(negedge clk);
        check("post-reset rd_valid", {31'h0, rd_valid}, 32'd0);
        check("post-reset count", {25'h0, count}, 32'd0);
        @(posedge clk);
        #1;
        wr_valid = 1'b1; wr_data = 8'hAA;
        @(negedge clk);
        check("post-reset push ram_we", {31'h0, ram_we}, 32'd1);
        check("post-reset push ram_addr", {26'h0, ram_addr}, 32'd0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        begin
            int waited = 0;
            @(negedge clk);
            while (rd_valid !== 1'b1 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
        end
        check("post-reset readback valid", {31'h0, rd_valid}, 32'd1);
        check("post-reset readback data", {24'h0, rd_data}, 32'hAA);

        check("ram_we matches push handshake", proto_bad, 0);
        check("write address/data sequence", addr_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spram_fifo_ctrl.md
Name: spram_fifo_ctrl

Overview:
- FIFO controller that drives the single-port RAM: data, addr and we out, q back in.
- Accepts bytes from an upstream producer over a valid/ready handshake and stores them in the RAM.
- Reads them back in order into a registered output stage with its own valid/ready handshake.
- Arbitrates the one RAM port between writes and read prefetches each cycle.

Parameters:
- DATA_WIDTH, 8, width of the data path and RAM word.
- ADDR_WIDTH, 6, width of the RAM address.
- DEPTH, 64, number of RAM entries used; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  producer has a byte.
- wr_ready  out  1  push accepted on an edge where wr_valid && wr_ready.
- wr_data  in  DATA_WIDTH  pushed byte.
- rd_valid  out  1  rd_data holds the oldest byte.
- rd_ready  in  1  consumer takes rd_data on an edge where rd_valid && rd_ready.
- rd_data  out  DATA_WIDTH  registered output byte.
- ram_data  out  DATA_WIDTH  to RAM data; equals wr_data.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_WIDTH  from RAM q. Valid for the address presented with ram_we=0 on the previous edge (one-cycle read latency).
- count  out  ADDR_WIDTH+1  total bytes held: RAM + in-flight read + output register.

Behaviour:
- State: wr_ptr and rd_ptr (ADDR_WIDTH bits), mem_count (0..DEPTH), pend (read in flight), rd_valid, rd_data, prio (1 means read wins the next conflict).
- Pointer wrap: each pointer advances by 1 and wraps DEPTH-1 -> 0; it does not wrap at 2**ADDR_WIDTH.
- rd_req (combinational) = mem_count != 0 && !pend && (!rd_valid || rd_ready).
- wr_req (combinational) = wr_valid && mem_count != DEPTH.
- Grant:
  - Only one request present: it wins.
  - Both present: prio decides.
  - After any grant, prio <= (grant was write).
  - Result: under contention, reads and writes strictly alternate.
- wr_ready = !rst && mem_count != DEPTH && !(rd_req && read wins). This is combinational from rd_ready and state; there is no path from wr_valid.
- Read grant:
  - Drives ram_addr = rd_ptr, ram_we = 0.
  - On the edge: rd_ptr++, mem_count--, pend <= 1.
- Write grant:
  - Drives ram_addr = wr_ptr, ram_we = 1.
  - On the edge: wr_ptr++, mem_count++.
- No grant: ram_we = 0, ram_addr = rd_ptr.
- ram_we is forced to 0 while rst is high.
- Capture: when pend = 1, on the edge rd_data <= ram_q, rd_valid <= 1, pend <= 0.
- Pop: rd_valid && rd_ready with no capture on the same edge -> rd_valid <= 0; rd_data holds its value.
- pend and rd_valid are never both 1. A read is issued only if the output register will be empty after the edge.
- Simultaneous read grant and pop on the same edge: legal. rd_valid falls, then capture sets it on the next edge.
- Latency, empty FIFO:
  - Push accepted at edge E0; read issued at E1; rd_valid = 1 after E2.
  - count reads 1 from E0 onward.
- count = mem_count + pend + rd_valid. Maximum DEPTH+1: a full RAM plus the output register.
- Full: mem_count == DEPTH -> wr_ready = 0; a held wr_valid waits with no data loss.
- Empty: mem_count == 0 -> no read issued; rd_valid stays low once the output register drains.
- Throughput: at most one pop per 2 cycles in steady state, because a read is not issued while pend = 1.
- Reset: on a rising edge with rst = 1:
  - wr_ptr = rd_ptr = 0, mem_count = 0, pend = 0, rd_valid = 0, rd_data = 0, prio = 1.
  - Outputs during and after reset: count = 0, wr_ready = 0 while rst = 1.
  - An in-flight read is discarded.
  - RAM contents are not cleared, and stale contents are never presented.

Test Plan:
- Reset, then push 0x01, 0x02, 0x03 on consecutive accepted edges with rd_ready = 0. Required:
  - RAM written at addresses 0, 1, 2.
  - One read issued to address 0.
  - rd_valid = 1, rd_data = 0x01, count = 3; rd_data held stable while rd_ready = 0.
- From that state, hold rd_ready = 1 -> pops in the order 0x01, 0x02, 0x03. After the last pop: rd_valid = 0, count = 0, ram_we never asserted.
- Single push of 0x5A into an empty FIFO at edge E0 -> ram_addr = 0 read at E1, rd_valid = 1 with 0x5A after E2.
- Push 0x00..0x40 (65 bytes) with rd_ready = 0 -> count = 65, wr_ready = 0, and a held 66th byte is not written. Then set rd_ready = 1 -> all 65 bytes read back in order and the 66th byte follows.
- Hold wr_valid = 1 and rd_ready = 1 while streaming 200 incrementing bytes. Required:
  - Grants alternate every cycle under contention.
  - Both pointers wrap 63 -> 0 at least twice.
  - Output sequence is exactly 0..199 mod 256, with no loss or duplication.
- Assert rst for one edge while pend = 1 and count = 10. Required:
  - After the edge: rd_valid = 0, count = 0, ram_we = 0 during reset.
  - Then push 0xAA -> written at address 0 and read back as 0xAA.
